// File: rtl/id_ex_skid_reg_pkg.sv
// Shared pipeline-register definitions: default field widths and the flat bundle layout
// used by the ID/EX register and its IF/ID, EX/MEM, MEM/WB successors.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_WB_W   = 2;
    localparam int DEF_M_W    = 3;
    localparam int DEF_EX_W   = 5;

    localparam int BUNDLE_W = 4*DEF_DATA_W + 2*DEF_REG_W + DEF_WB_W + DEF_M_W + DEF_EX_W;

    // Control groups sit in the low bits so a flush can zero them with one slice.
    localparam int OFF_EX    = 0;
    localparam int OFF_M     = OFF_EX    + DEF_EX_W;
    localparam int OFF_WB    = OFF_M     + DEF_M_W;
    localparam int OFF_INS15 = OFF_WB    + DEF_WB_W;
    localparam int OFF_INS20 = OFF_INS15 + DEF_REG_W;
    localparam int OFF_SEXT  = OFF_INS20 + DEF_REG_W;
    localparam int OFF_RD2   = OFF_SEXT  + DEF_DATA_W;
    localparam int OFF_RD1   = OFF_RD2   + DEF_DATA_W;
    localparam int OFF_PC4   = OFF_RD1   + DEF_DATA_W;

    function automatic int bundle_w(int dw, int rw, int wb, int m, int ex);
        return 4*dw + 2*rw + wb + m + ex;
    endfunction

    function automatic int ctrl_w(int wb, int m, int ex);
        return wb + m + ex;
    endfunction

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// Decode-side and EX-side handshake plus payload of the ID/EX register.
interface id_ex_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc_plus4, in_rd1, in_rd2, in_sign_ext;
    logic [REG_W-1:0]  in_ins20, in_ins15;
    logic [WB_W-1:0]   in_wb;
    logic [M_W-1:0]    in_m;
    logic [EX_W-1:0]   in_ex;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_pc_plus4, out_rd1, out_rd2, out_sign_ext;
    logic [REG_W-1:0]  out_ins20, out_ins15;
    logic [WB_W-1:0]   out_wb;
    logic [M_W-1:0]    out_m;
    logic [EX_W-1:0]   out_ex;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_pc_plus4, in_rd1, in_rd2, in_sign_ext, in_ins20, in_ins15,
               in_wb, in_m, in_ex, flush, out_ready,
        input  in_ready, out_valid, out_pc_plus4, out_rd1, out_rd2, out_sign_ext,
               out_ins20, out_ins15, out_wb, out_m, out_ex, occupancy
    );

    modport slave (
        input  in_valid, in_pc_plus4, in_rd1, in_rd2, in_sign_ext, in_ins20, in_ins15,
               in_wb, in_m, in_ex, flush, out_ready,
        output in_ready, out_valid, out_pc_plus4, out_rd1, out_rd2, out_sign_ext,
               out_ins20, out_ins15, out_wb, out_m, out_ex, occupancy
    );
endinterface

// File: rtl/id_ex_skid_reg_slot.sv
// One bundle-wide storage slot with valid bit; an invalid slot always holds zero control bits.
module skid_slot #(
    parameter int W      = 8,
    parameter int CTRL_W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         ld,
    input  logic         vld_d,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (flush) begin
            vld              <= 1'b0;
            q[CTRL_W-1:0]    <= '0;
        end else if (ld) begin
            vld <= vld_d;
            // Data of a bubble is don't-care; only the control slice must go quiet.
            if (vld_d) q <= d;
            else       q[CTRL_W-1:0] <= '0;
        end
    end
endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register: main slot drives EX, skid slot absorbs one entry during a stall.
module id_ex_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int WB_W   = DEF_WB_W,
    parameter int M_W    = DEF_M_W,
    parameter int EX_W   = DEF_EX_W
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_skid_reg_if.slave bus
);
    localparam int BW = bundle_w(DATA_W, REG_W, WB_W, M_W, EX_W);
    localparam int CW = ctrl_w(WB_W, M_W, EX_W);

    logic [BW-1:0] in_b, main_d, main_q, skid_q;
    logic          main_vld, skid_vld, in_xfer, adv;
    logic          main_vld_d, skid_vld_d, skid_ld;

    assign in_b = {bus.in_pc_plus4, bus.in_rd1, bus.in_rd2, bus.in_sign_ext,
                   bus.in_ins20, bus.in_ins15, bus.in_wb, bus.in_m, bus.in_ex};

    assign bus.in_ready = ~skid_vld;
    assign in_xfer      = bus.in_valid & ~skid_vld;
    // Main advances when empty or when EX takes its entry.
    assign adv          = ~main_vld | bus.out_ready;

    assign main_vld_d = skid_vld | in_xfer;
    assign main_d     = skid_vld ? skid_q : in_b;
    assign skid_ld    = adv | in_xfer;
    assign skid_vld_d = adv ? (skid_vld & in_xfer) : in_xfer;

    skid_slot #(.W(BW), .CTRL_W(CW)) u_main (
        .clk(clk), .rst(rst), .flush(bus.flush), .ld(adv),
        .vld_d(main_vld_d), .d(main_d), .vld(main_vld), .q(main_q)
    );

    skid_slot #(.W(BW), .CTRL_W(CW)) u_skid (
        .clk(clk), .rst(rst), .flush(bus.flush), .ld(skid_ld),
        .vld_d(skid_vld_d), .d(in_b), .vld(skid_vld), .q(skid_q)
    );

    assign bus.out_valid = main_vld;
    assign {bus.out_pc_plus4, bus.out_rd1, bus.out_rd2, bus.out_sign_ext,
            bus.out_ins20, bus.out_ins15, bus.out_wb, bus.out_m, bus.out_ex} = main_q;
    assign bus.occupancy = {1'b0, main_vld} + {1'b0, skid_vld};
endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench driving a 32-bit and a 64-bit instance with identical directed stimulus.
module tb_id_ex_skid_reg;

    typedef struct packed {
        logic [63:0] pc, rd1, rd2, se;
        logic [5:0]  i20, i15;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [4:0]  ex;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t act0, act1;

    always #5 clk = ~clk;

    id_ex_skid_reg_if b0 ();
    id_ex_skid_reg_if #(.DATA_W(64), .REG_W(6)) b1 ();

    id_ex_skid_reg u0 (.clk(clk), .rst(rst), .bus(b0));
    id_ex_skid_reg #(.DATA_W(64), .REG_W(6)) u1 (.clk(clk), .rst(rst), .bus(b1));

    function automatic exp_t mk(logic [63:0] v, logic [5:0] i20, logic [1:0] wb,
                                logic [2:0] m, logic [4:0] ex, bit wide);
        exp_t        e;
        logic [63:0] msk = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        logic [5:0]  rm  = wide ? 6'h3F : 6'h1F;
        e.pc  = (v + 64'd4) & msk;
        e.rd1 = v & msk;
        e.rd2 = (~v) & msk;
        e.se  = (v << 1) & msk;
        e.i20 = i20 & rm;
        e.i15 = (i20 + 6'd1) & rm;
        e.wb  = wb;
        e.m   = m;
        e.ex  = ex;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_ent(string tag, exp_t e, exp_t a);
        n_chk++;
        if (e !== a) begin
            n_fail++;
            $display("FAIL %s: got rd1=%0h pc=%0h rd2=%0h se=%0h i20=%0h i15=%0h wb=%0h m=%0h ex=%0h expected rd1=%0h pc=%0h rd2=%0h se=%0h i20=%0h i15=%0h wb=%0h m=%0h ex=%0h",
                     tag, a.rd1, a.pc, a.rd2, a.se, a.i20, a.i15, a.wb, a.m, a.ex,
                     e.rd1, e.pc, e.rd2, e.se, e.i20, e.i15, e.wb, e.m, e.ex);
        end
    endtask

    // One clock of stimulus; the expected entry is queued at the edge that accepts it.
    task automatic step(logic vld, logic [63:0] v, logic [5:0] i20, logic [1:0] wb,
                        logic [2:0] m, logic [4:0] ex, logic ordy, logic fl, logic rs);
        logic [63:0] pc, r2, se;
        logic [5:0]  i15;
        logic        a0, a1;
        pc  = v + 64'd4;
        r2  = ~v;
        se  = v << 1;
        i15 = i20 + 6'd1;
        rst = rs;
        b0.in_valid = vld;      b1.in_valid = vld;
        b0.in_pc_plus4 = pc[31:0]; b1.in_pc_plus4 = pc;
        b0.in_rd1 = v[31:0];    b1.in_rd1 = v;
        b0.in_rd2 = r2[31:0];   b1.in_rd2 = r2;
        b0.in_sign_ext = se[31:0]; b1.in_sign_ext = se;
        b0.in_ins20 = i20[4:0]; b1.in_ins20 = i20;
        b0.in_ins15 = i15[4:0]; b1.in_ins15 = i15;
        b0.in_wb = wb; b1.in_wb = wb;
        b0.in_m  = m;  b1.in_m  = m;
        b0.in_ex = ex; b1.in_ex = ex;
        b0.flush = fl; b1.flush = fl;
        b0.out_ready = ordy; b1.out_ready = ordy;
        @(negedge clk);
        a0 = vld && b0.in_ready && !fl && !rs;
        a1 = vld && b1.in_ready && !fl && !rs;
        @(posedge clk);
        if (rs || fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (a0) q0.push_back(mk(v, i20, wb, m, ex, 1'b0));
            if (a1) q1.push_back(mk(v, i20, wb, m, ex, 1'b1));
        end
        #1;
    endtask

    task automatic idle(logic ordy);
        step(1'b0, 64'd0, 6'd0, 2'd0, 3'd0, 5'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic put(logic [63:0] v, logic ordy);
        step(1'b1, v, v[5:0], 2'b10, 3'b101, 5'b10011, ordy, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            act0 = '{pc: {32'd0, b0.out_pc_plus4}, rd1: {32'd0, b0.out_rd1},
                     rd2: {32'd0, b0.out_rd2}, se: {32'd0, b0.out_sign_ext},
                     i20: {1'b0, b0.out_ins20}, i15: {1'b0, b0.out_ins15},
                     wb: b0.out_wb, m: b0.out_m, ex: b0.out_ex};
            act1 = '{pc: b1.out_pc_plus4, rd1: b1.out_rd1, rd2: b1.out_rd2,
                     se: b1.out_sign_ext, i20: b1.out_ins20, i15: b1.out_ins15,
                     wb: b1.out_wb, m: b1.out_m, ex: b1.out_ex};
            if (b0.out_valid && b0.out_ready) begin
                if (q0.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb32_unexpected: got rd1=%0h expected no entry", b0.out_rd1);
                end else cmp_ent("sb32", q0.pop_front(), act0);
            end
            if (b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb64_unexpected: got rd1=%0h expected no entry", b1.out_rd1);
                end else cmp_ent("sb64", q1.pop_front(), act1);
            end
            if (!b0.out_valid) chk("bubble32", 64'({b0.out_wb, b0.out_m, b0.out_ex}), 64'd0);
            if (!b1.out_valid) chk("bubble64", 64'({b1.out_wb, b1.out_m, b1.out_ex}), 64'd0);
        end
    end

    task automatic stall_seq(logic [63:0] v0);
        put(v0, 1'b1);
        chk("stall_occ1", 64'(b0.occupancy), 64'd1);
        put(v0 + 64'd1, 1'b0);
        chk("stall_occ2", 64'(b0.occupancy), 64'd2);
        chk("stall_occ2_w", 64'(b1.occupancy), 64'd2);
        chk("stall_rdy0", 64'(b0.in_ready), 64'd0);
        chk("stall_rdy0_w", 64'(b1.in_ready), 64'd0);
        put(v0 + 64'd2, 1'b0);
        chk("stall_hold_w", b1.out_rd1, v0);
        put(v0 + 64'd2, 1'b1);
        chk("stall_skid_w", b1.out_rd1, v0 + 64'd1);
        put(v0 + 64'd2, 1'b1);
        chk("stall_last_w", b1.out_rd1, v0 + 64'd2);
        idle(1'b1);
        chk("stall_drain", 64'(q0.size() + q1.size()), 64'd0);
        chk("stall_empty", 64'(b0.out_valid), 64'd0);
    endtask

    initial begin
        // Reset then a single entry
        step(1'b0, 64'd0, 6'd0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 64'd0, 6'd0, 2'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("rst_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_occ", 64'(b0.occupancy), 64'd0);
        chk("rst_ready", 64'(b0.in_ready), 64'd1);
        chk("rst_rd1", 64'(b0.out_rd1), 64'd0);
        chk("rst_wb", 64'(b0.out_wb), 64'd0);
        step(1'b1, 64'h0000_00AA, 6'd9, 2'b11, 3'b010, 5'b00101, 1'b1, 1'b0, 1'b0);
        chk("one_valid", 64'(b0.out_valid), 64'd1);
        chk("one_rd1", 64'(b0.out_rd1), 64'h0000_00AA);
        chk("one_ins20", 64'(b0.out_ins20), 64'd9);
        chk("one_wb", 64'(b0.out_wb), 64'd3);
        chk("one_occ", 64'(b0.occupancy), 64'd1);
        idle(1'b1);
        chk("one_after_valid", 64'(b0.out_valid), 64'd0);
        chk("one_after_wb", 64'(b0.out_wb), 64'd0);

        // Back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            chk("stream_ready", 64'(b0.in_ready), 64'd1);
            put(64'(i), 1'b1);
            chk("stream_rd1", 64'(b0.out_rd1), 64'(i));
        end
        idle(1'b1);

        // Stall absorption, narrow and full-width values
        stall_seq(64'd10);
        stall_seq(64'hDEAD_BEEF_0000_0001);

        // Flush with a full skid, then with an accepted input
        put(64'h20, 1'b1);
        put(64'h21, 1'b0);
        chk("fl_occ2", 64'(b0.occupancy), 64'd2);
        step(1'b1, 64'h55, 6'd3, 2'b11, 3'b111, 5'b11111, 1'b0, 1'b1, 1'b0);
        chk("fl_valid", 64'(b0.out_valid), 64'd0);
        chk("fl_occ", 64'(b0.occupancy), 64'd0);
        chk("fl_m", 64'(b0.out_m), 64'd0);
        chk("fl_ex", 64'(b0.out_ex), 64'd0);
        put(64'h30, 1'b0);
        chk("fl2_ready", 64'(b0.in_ready), 64'd1);
        step(1'b1, 64'h55, 6'd3, 2'b11, 3'b111, 5'b11111, 1'b0, 1'b1, 1'b0);
        chk("fl2_occ", 64'(b1.occupancy), 64'd0);
        idle(1'b1);
        idle(1'b1);
        chk("fl_nothing", 64'(b0.out_valid), 64'd0);

        // Reset mid-stall
        put(64'h40, 1'b1);
        put(64'h41, 1'b0);
        step(1'b1, 64'h42, 6'd2, 2'b11, 3'b111, 5'b11111, 1'b0, 1'b0, 1'b1);
        chk("rs_valid", 64'(b0.out_valid), 64'd0);
        chk("rs_occ", 64'(b0.occupancy), 64'd0);
        chk("rs_ready", 64'(b0.in_ready), 64'd1);
        chk("rs_rd1", 64'(b0.out_rd1), 64'd0);
        chk("rs_ctrl", 64'({b0.out_wb, b0.out_m, b0.out_ex}), 64'd0);
        put(64'h77, 1'b1);
        chk("rs_new_valid", 64'(b0.out_valid), 64'd1);
        chk("rs_new_rd1", 64'(b0.out_rd1), 64'h77);
        idle(1'b1);
        idle(1'b1);
        chk("final_drain", 64'(q0.size() + q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- Parametrised ID/EX pipeline register for the 5-stage datapath, replacing the fixed-width, always-loading stage register.
- Carries the decode payload (PC+4, RD1, RD2, sign-extended immediate, rt/rd indices) and the WB/M/EX control groups into EX.
- Adds synchronous reset, valid/ready handshake, a 2-entry skid buffer for stall absorption, and flush with bubble insertion.
- Sits between the decode stage and the EX stage; hazard logic drives out_ready (stall) and flush.

Parameters:
- DATA_W, 32, width of the pc_plus4/rd1/rd2/sign_ext fields
- REG_W, 5, width of the register-index fields ins20/ins15
- WB_W, 2, width of the WB control group
- M_W, 3, width of the MEM control group
- EX_W, 5, width of the EX control group

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  decode presents a valid instruction
- in_ready  out  1  register can accept; equals NOT skid_valid
- in_pc_plus4, in_rd1, in_rd2, in_sign_ext  in  DATA_W each  decode data fields
- in_ins20, in_ins15  in  REG_W each  register index fields
- in_wb  in  WB_W  WB control
- in_m  in  M_W  MEM control
- in_ex  in  EX_W  EX control
- flush  in  1  kill all held and incoming entries this cycle
- out_ready  in  1  EX accepts (0 = stall)
- out_valid  out  1  main slot holds a valid entry
- out_pc_plus4, out_rd1, out_rd2, out_sign_ext  out  DATA_W each  registered data fields
- out_ins20, out_ins15  out  REG_W each  registered index fields
- out_wb, out_m, out_ex  out  WB_W/M_W/EX_W  registered control; forced to zero when out_valid=0
- occupancy  out  2  number of valid entries held (0..2)

Behaviour:
- Storage and handshake
  - Two slots: main (drives outputs) and skid.
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - All state updates occur on the rising edge of clk.
- Reset (rst=1, synchronous)
  - main_valid = skid_valid = 0.
  - All out_* fields = 0, occupancy = 0.
  - in_ready = 1 in the first cycle after reset.
  - rst has priority over flush and all transfers.
- Flush (flush=1, rst=0)
  - main_valid and skid_valid cleared; control fields of both slots zeroed.
  - An in_xfer in the same cycle is discarded.
  - Next cycle: out_valid = 0, occupancy = 0.
  - Data fields may retain stale values.
- Normal update (no rst/flush)
  - Main empty or out_xfer: main loads the skid entry if skid_valid, else the input if in_xfer, else becomes invalid.
  - Skid slot after that case: if skid was moved to main and in_xfer, the input goes to skid; otherwise skid becomes empty.
  - Main full, no out_xfer, in_xfer: input goes to skid.
    - in_ready is 1 only when skid is empty, so skid never overflows.
  - Main full, no out_xfer, no in_xfer: hold.
- Latency and throughput
  - Latency from in_xfer to out_valid is 1 cycle when empty.
  - Throughput is 1 entry/cycle while out_ready=1.
  - Order is strictly FIFO.
- Bubble rule
  - out_wb/out_m/out_ex = 0 whenever out_valid = 0, so downstream writes and memory ops are suppressed.
- Occupancy
  - occupancy = main_valid + skid_valid.
- Stall behaviour
  - One stall cycle with continuous input fills the skid.
  - A second consecutive stall deasserts in_ready.
  - A simultaneous in_xfer and out_xfer with a full skid cannot occur.

Decomposition:
- Shared package pipe_pkg
  - default widths: DATA_W, REG_W, WB_W, M_W, EX_W
  - the bundle width constant: BUNDLE_W = 4*DATA_W + 2*REG_W + WB_W + M_W + EX_W
  - bundle field offset localparams, reused by the IF/ID, EX/MEM and MEM/WB successors
- Natural sub-module: skid_slot
  - one BUNDLE_W-wide register with valid bit, load enable and synchronous clear-control-on-flush
  - instantiated twice

Test Plan:
1. Reset then a single entry: assert rst 2 cycles, then drive in_valid=1 for 1 cycle with rd1=0x0000_00AA, in_ins20=5'd9, in_wb=2'b11, out_ready=1.
   -> Next cycle out_valid=1, out_rd1=0x0000_00AA, out_ins20=9, out_wb=2'b11, occupancy=1.
   -> Following cycle out_valid=0, out_wb=0.
2. Back-to-back stream: present values 1,2,3,4 in consecutive cycles with out_ready=1.
   -> out_rd1 shows 1,2,3,4 on consecutive cycles, one cycle behind the input.
   -> in_ready stays 1 throughout.
3. Stall absorption: stream values 10,11,12 and drop out_ready for 2 cycles starting when 10 is in main.
   -> 11 goes to skid; in_ready=0 during the second stall cycle; occupancy=2.
   -> After release, 10,11,12 appear in order with no loss or duplication.
4. Flush with a full skid: occupancy=2, then assert flush together with in_valid=1 (value 0x55).
   -> Next cycle out_valid=0, occupancy=0, out_m=0, out_ex=0.
   -> 0x55 never appears on the outputs.
5. Reset mid-stall: occupancy=2 and out_ready=0; assert rst together with flush=0 and in_valid=1.
   -> Next cycle all outputs 0, in_ready=1.
   -> A new entry 0x77 after reset emerges 1 cycle later.
6. Parameter sweep: instantiate DATA_W=64, REG_W=6 and repeat scenario 3 using value 0xDEAD_BEEF_0000_0001.
   -> Full-width value preserved through the skid path.
